// File: rtl/rr_arbiter_4_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter.
// Holds the requester count, index width, FSM state enum and default hold limit.
package arb_pkg;

    localparam int NREQ         = 4;
    localparam int IDX_W        = 2;
    localparam int MAX_HOLD_DEF = 8;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [NREQ-1:0]  vec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    function automatic vec_t idx2onehot(input idx_t idx);
        return vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requester front-ends (master) and the arbiter (slave).
interface rr_arbiter_4_if;
    import arb_pkg::*;

    vec_t req;
    vec_t gnt;
    idx_t gnt_id;
    logic gnt_valid;
    logic preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output preempt
    );

endinterface

// File: rtl/rr_arbiter_4_penc.sv
// Existing 4:2 priority encoder: bit 3 has highest priority, valid flags any set input.
module priority_encoder_4to2 (
    input  logic [3:0] in,
    output logic [1:0] out,
    output logic       valid
);

    always_comb begin
        valid = |in;
        out   = 2'd0;
        if (in[3])      out = 2'd3;
        else if (in[2]) out = 2'd2;
        else if (in[1]) out = 2'd1;
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant.
// Optional forced rotation after MAX_HOLD owned cycles when `ARB_HOLD_LIMIT_EN is defined.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter_4_if.slave bus
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    arb_state_t state_p0, state_p1;
    idx_t       last_p0, last_p1;
    vec_t       gnt_p0, gnt_p1;
    idx_t       id_p0, id_p1;
    logic       vld_p0, vld_p1;

    vec_t       req_rot;
    logic [1:0] enc_out;
    logic       enc_valid;
    idx_t       winner;
    logic       others;
    logic       grant_new;

    // Rotate so the requester right after the last winner lands on encoder bit 3.
    always_comb begin
        req_rot = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_rot[k] = bus.req[idx_t'(last_p1 - idx_t'(k))];
        end
    end

    priority_encoder_4to2 u_penc (
        .in    (req_rot),
        .out   (enc_out),
        .valid (enc_valid)
    );

    assign winner = idx_t'(last_p1 - enc_out);
    assign others = |(bus.req & ~gnt_p1);

`ifdef ARB_HOLD_LIMIT_EN
    logic [7:0] cnt_p0, cnt_p1;
    logic       pre_p0, pre_p1;
`else
    logic [7:0] unused_hold;
    assign unused_hold = HOLD_LIM;
`endif

    always_comb begin
        state_p0  = state_p1;
        last_p0   = last_p1;
        gnt_p0    = gnt_p1;
        id_p0     = id_p1;
        vld_p0    = vld_p1;
        grant_new = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
        cnt_p0    = cnt_p1;
        pre_p0    = 1'b0;
`endif
        case (state_p1)
            IDLE: begin
                if (enc_valid) grant_new = 1'b1;
            end
            OWNED: begin
                // In OWNED the last winner is the owner, so it sits at lowest priority.
                if (!bus.req[last_p1]) begin
                    if (enc_valid) begin
                        grant_new = 1'b1;
                    end else begin
                        state_p0 = IDLE;
                        gnt_p0   = '0;
                        id_p0    = '0;
                        vld_p0   = 1'b0;
                    end
                end
`ifdef ARB_HOLD_LIMIT_EN
                else if (cnt_p1 >= HOLD_LIM && others) begin
                    grant_new = 1'b1;
                    pre_p0    = 1'b1;
                end else if (cnt_p1 != 8'hFF) begin
                    cnt_p0 = cnt_p1 + 8'd1;
                end
`endif
            end
            default: state_p0 = IDLE;
        endcase
        if (grant_new) begin
            state_p0 = OWNED;
            last_p0  = winner;
            gnt_p0   = idx2onehot(winner);
            id_p0    = winner;
            vld_p0   = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
            cnt_p0   = 8'd0;
`endif
        end
    end

    // Registered outputs: single stage from the deciding edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_p1 <= IDLE;
            last_p1  <= idx_t'(NREQ - 1);
            gnt_p1   <= '0;
            id_p1    <= '0;
            vld_p1   <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            cnt_p1   <= 8'd0;
            pre_p1   <= 1'b0;
`endif
        end else begin
            state_p1 <= state_p0;
            last_p1  <= last_p0;
            gnt_p1   <= gnt_p0;
            id_p1    <= id_p0;
            vld_p1   <= vld_p0;
`ifdef ARB_HOLD_LIMIT_EN
            cnt_p1   <= cnt_p0;
            pre_p1   <= pre_p0;
`endif
        end
    end

    assign bus.gnt       = gnt_p1;
    assign bus.gnt_id    = id_p1;
    assign bus.gnt_valid = vld_p1;
`ifdef ARB_HOLD_LIMIT_EN
    assign bus.preempt   = pre_p1;
`else
    assign bus.preempt   = 1'b0;
`endif

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter that shares one downstream resource among requesters 0..3. Request vector is rotated by the last winner and resolved with the existing 4:2 priority encoder; the winner holds a registered one-hot grant until it drops its request. Sits between requester front-ends and the shared resource; its grant also drives that resource's select mux.

## Interface
- `NREQ`, 4: number of requesters; fixed at 4 by encoder width, not overridable.
- `MAX_HOLD`, 8: max consecutive grant cycles before forced rotation (used only with `ARB_HOLD_LIMIT_EN`); legal range 1..255.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  4  request per requester; held high for the whole tenure.
- `gnt`  out  4  one-hot grant, registered; all-zero when idle.
- `gnt_id`  out  2  index of current owner; 0 when idle.
- `gnt_valid`  out  1  high iff `gnt` nonzero.
- `preempt`  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- States: IDLE (no owner), OWNED (owner = `gnt_id`).
- Priority order after last winner L: L+1, L+2, L+3, L (mod 4). Reset value of L = 3, so first order is 0,1,2,3.
- Arbitration: rotate `req` so the highest-priority slot maps to encoder bit 3; encoder `out` is un-rotated back to a requester index; encoder `valid` = any request.
- IDLE: if any `req` bit high at an edge -> OWNED with winner, L <= winner. Else stay.
- OWNED, `req[owner]` high: hold grant, L unchanged.
- OWNED, `req[owner]` low: release at that edge. If other requests are pending, grant the next winner at the same edge (no idle bubble). Otherwise -> IDLE, `gnt` = 0.
- A released owner re-asserting competes normally; it has lowest priority until someone else wins.
- Requests that drop before being granted are forgotten; no request queuing.
- `gnt` never has more than one bit set; never grants a requester whose `req` was low at the deciding edge.

## Timing
- Reset (`rst_n` low at an edge): `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `preempt`=0, state IDLE, L=3, hold counter 0. Applies mid-tenure: grant drops at that edge, no handover.
- Grant latency: 1 cycle. `req` sampled at edge N -> `gnt` visible after edge N.
- Release-to-next-grant: 0 bubble cycles. The edge that sees owner `req` low also loads the new owner.
- All outputs registered; no combinational path from `req` to any output.

## Configuration
- `ARB_HOLD_LIMIT_EN` defined: 8-bit hold counter clears on every new grant and increments each OWNED cycle. When the count reaches `MAX_HOLD` cycles of ownership with another request pending, the owner is revoked at that edge. The next winner is granted at the same edge, `preempt` pulses for one cycle, and the counter restarts. With no other request pending, the owner keeps the grant and the counter saturates.
- Not defined: no counter; grant held until the owner releases; `preempt` tied 0.

## Structure
- Shared package `arb_pkg`: `NREQ`, index width (2), state enum {IDLE, OWNED}, default `MAX_HOLD`.
- One sub-module: the existing `priority_encoder_4to2` (bit 3 highest, `valid` output), instantiated once on the rotated request vector. Rotation, un-rotation, FSM and counter live in `rr_arbiter_4`.

## Test plan
- Reset with `req`=4'b1111 held -> all outputs 0 while `rst_n` low; first edge after release gives `gnt`=4'b0001, `gnt_id`=0.
- Single `req`=4'b0100 from IDLE -> `gnt`=4'b0100 one cycle later; hold 5 cycles; drop -> `gnt`=0 next edge, state IDLE.
- `req`=4'b1111, each owner drops for 1 cycle after 2 cycles -> grant order 0,1,2,3,0 with zero bubble between owners.
- Owner 2 releases while `req`=4'b0011 -> next `gnt`=4'b0001 (order 3,0,1); re-asserted `req[2]` waits until both are served.
- `ARB_HOLD_LIMIT_EN`, `MAX_HOLD`=4, `req`=4'b0011 held constantly -> grant alternates 0,1,0 every 4 cycles, `preempt` pulses at each switch. With only `req`=4'b0001 held -> no preempt.
- `rst_n` low mid-tenure with owner 3 -> `gnt`=0 at that edge. After reset, `req`=4'b1001 -> grant 0 (L restored to 3).
